sprite_blitter: RTL and testbench



---
 rtl/sprite_blitter.sv | 112 +++++++++++
 tb/tb_sprite_blitter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a ROM sprite into the framebuffer at a run-time origin with clipping, transparency and erase.
module sprite_blitter #(
    parameter int SPR_W = 40,
    parameter int SPR_H = 40,
    parameter int ADDR_W = 11,
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3,
    parameter int ROM_LAT = 1,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic TRANSP_EN = 1'b1,
    parameter logic [C_W-1:0] TRANSP_COLOUR = 3'b111
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [X_W-1:0]    x_origin,
    input  logic [Y_W-1:0]    y_origin,
    input  logic              erase,
    input  logic [C_W-1:0]    bg_colour,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [C_W-1:0]    rom_q,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic [C_W-1:0]    c_out,
    output logic              plot,
    output logic              busy,
    output logic              done
);
    localparam int CW = SPR_W > 1 ? $clog2(SPR_W) : 1;
    localparam int RW = SPR_H > 1 ? $clog2(SPR_H + 1) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [2:0] drain_cnt;
    logic [X_W-1:0] x_org;
    logic [Y_W-1:0] y_org;
    logic er;
    logic [C_W-1:0] bg;
    logic [CW-1:0] d_col [ROM_LAT];
    logic [RW-1:0] d_row [ROM_LAT];
    logic [ROM_LAT-1:0] d_vld;
    logic last, col_end, vld, vis;
    logic [X_W:0] xs;
    logic [Y_W:0] ys;
    assign col_end = col == CW'(SPR_W - 1);
    assign last = col_end && row == RW'(SPR_H - 1);
    always_ff @(posedge clock) state <= !reset_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = last ? DRAIN : RUN;
            DRAIN:   state_nx = drain_cnt == 3'(ROM_LAT - 1) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
            rom_addr <= '0;
            drain_cnt <= '0;
            x_org <= '0;
            y_org <= '0;
            er <= 1'b0;
            bg <= '0;
            d_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                d_col[i] <= '0;
                d_row[i] <= '0;
            end
        end else begin
            // slot tags ride alongside the ROM read so each one meets its rom_q
            d_vld[0] <= state == RUN;
            d_col[0] <= col;
            d_row[0] <= row;
            for (int i = 1; i < ROM_LAT; i++) begin
                d_vld[i] <= d_vld[i-1];
                d_col[i] <= d_col[i-1];
                d_row[i] <= d_row[i-1];
            end
            drain_cnt <= state == DRAIN ? drain_cnt + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                x_org <= x_origin;
                y_org <= y_origin;
                er <= erase;
                bg <= bg_colour;
                col <= '0;
                row <= '0;
                rom_addr <= '0;
            end else if (state == RUN) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                col <= col_end ? '0 : col + CW'(1);
                row <= col_end ? row + RW'(1) : row;
            end
        end
    end
    // sums carry one extra bit so off-screen pixels are not folded back by truncation
    assign vld = d_vld[ROM_LAT-1];
    assign xs = {1'b0, x_org} + (X_W+1)'(d_col[ROM_LAT-1]);
    assign ys = {1'b0, y_org} + (Y_W+1)'(d_row[ROM_LAT-1]);
    assign vis = vld && xs < (X_W+1)'(SCREEN_W) && ys < (Y_W+1)'(SCREEN_H);
    assign plot = vis && !(TRANSP_EN && !er && rom_q == TRANSP_COLOUR);
    assign x_out = vld ? xs[X_W-1:0] : '0;
    assign y_out = vld ? ys[Y_W-1:0] : '0;
    assign c_out = !vld ? '0 : er ? bg : rom_q;
    assign busy = state == RUN || state == DRAIN;
    assign done = state == DONE;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized scoreboard bench for sprite_blitter with a behavioural ROM and pixel model.
module tb_sprite_blitter;
    localparam int W = 40;
    localparam int H = 40;
    localparam int N = W * H;
    localparam int LAT = 3;
    typedef struct {int t; int x; int y; int c;} ev_t;
    logic clock = 1'b0;
    logic reset_n, start, erase;
    logic [7:0] x_origin;
    logic [6:0] y_origin;
    logic [2:0] bg_colour, rom_q, c_out;
    logic [10:0] rom_addr;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic plot, busy, done;
    logic [2:0] rom [2048];
    logic [2:0] qd [LAT];
    ev_t q[$];
    ev_t mon_e;
    logic exp_p;
    logic mon_en = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int nplot = 0;
    int b_lo = 1 << 30;
    int b_hi = -1;
    int done_exp = -1;

    sprite_blitter #(.SPR_W(W), .SPR_H(H), .ROM_LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .x_origin(x_origin),
        .y_origin(y_origin), .erase(erase), .bg_colour(bg_colour), .rom_addr(rom_addr),
        .rom_q(rom_q), .x_out(x_out), .y_out(y_out), .c_out(c_out), .plot(plot),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) begin
        qd[0] <= rom[rom_addr];
        for (int i = 1; i < LAT; i++) qd[i] <= qd[i-1];
    end
    assign rom_q = qd[LAT-1];

    always @(negedge clock) if (mon_en) begin
        while (q.size() > 0 && q[0].t < cyc) begin
            checks++;
            errors++;
            $display("FAIL plot_missing cyc=%0d got no plot, expected (%0d,%0d,c=%0d) at %0d", cyc, q[0].x, q[0].y, q[0].c, q[0].t);
            void'(q.pop_front());
        end
        exp_p = q.size() > 0 && q[0].t == cyc;
        checks++;
        if (plot !== exp_p) begin
            errors++;
            $display("FAIL plot_strobe cyc=%0d got %b expected %b (x=%0d y=%0d)", cyc, plot, exp_p, x_out, y_out);
        end else if (plot) begin
            mon_e = q.pop_front();
            checks++;
            if (x_out !== 8'(mon_e.x) || y_out !== 7'(mon_e.y) || c_out !== 3'(mon_e.c)) begin
                errors++;
                $display("FAIL pixel cyc=%0d got (%0d,%0d,c=%0d) expected (%0d,%0d,c=%0d)", cyc, x_out, y_out, c_out, mon_e.x, mon_e.y, mon_e.c);
            end
        end
        if (plot === 1'b1) nplot++;
        checks++;
        if (busy !== (cyc >= b_lo && cyc <= b_hi)) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b expected %b", cyc, busy, cyc >= b_lo && cyc <= b_hi);
        end
        checks++;
        if (done !== (cyc == done_exp)) begin
            errors++;
            $display("FAIL done cyc=%0d got %b expected %b", cyc, done, cyc == done_exp);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic blit(input int xo, input int yo, input logic er, input logic [2:0] bg,
                        input int poke_k, input int rst_k, input logic dpoke);
        int tacc, n0, nexp, bad;
        @(negedge clock);
        x_origin = 8'(xo);
        y_origin = 7'(yo);
        erase = er;
        bg_colour = bg;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        x_origin = 8'($urandom);
        y_origin = 7'($urandom);
        erase = 1'($urandom);
        bg_colour = 3'($urandom);
        tacc = cyc;
        b_lo = tacc;
        b_hi = tacc + N + LAT - 1;
        done_exp = tacc + N + LAT;
        n0 = nplot;
        nexp = 0;
        for (int k = 0; k < N; k++) begin
            int xs = xo + k % W;
            int ys = yo + k / W;
            logic [2:0] v = rom[k];
            if (xs < 160 && ys < 120 && (er || v != 3'b111)) begin
                q.push_back('{tacc + k + LAT, xs, ys, er ? int'(bg) : int'(v)});
                nexp++;
            end
        end
        bad = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clock);
            if (rom_addr !== 11'(k)) bad++;
            start = k == poke_k;
            if (k == rst_k) begin
                chk("addr_seq_before_reset", bad, 0);
                reset_n = 1'b0;
                @(posedge clock);
                #1;
                q.delete();
                b_lo = 1 << 30;
                b_hi = -1;
                done_exp = -1;
                @(negedge clock);
                chk("reset_plot", int'(plot), 0);
                chk("reset_busy", int'(busy), 0);
                chk("reset_addr", int'(rom_addr), 0);
                reset_n = 1'b1;
                return;
            end
        end
        start = 1'b0;
        chk("addr_seq", bad, 0);
        for (int i = 0; i < LAT + 8 && cyc <= done_exp; i++) begin
            @(negedge clock);
            start = dpoke && cyc == done_exp;
        end
        start = 1'b0;
        chk("done_reached", int'(cyc > done_exp), 1);
        repeat (LAT + 3) @(negedge clock);
        chk("pending_pixels", q.size(), 0);
        chk("plot_count", nplot - n0, nexp);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        erase = 1'b0;
        x_origin = '0;
        y_origin = '0;
        bg_colour = '0;
        for (int i = 0; i < 2048; i++) rom[i] = 3'(i % 7);
        repeat (3) @(negedge clock);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x_out), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_c", int'(c_out), 0);
        reset_n = 1'b1;
        @(negedge clock);
        mon_en = 1'b1;
        blit(60, 6, 1'b0, 3'd0, -1, -1, 1'b0);
        rom[5] = 3'b111;
        blit(60, 6, 1'b0, 3'd0, -1, -1, 1'b0);
        for (int i = 0; i < 2048; i++) rom[i] = 3'($urandom_range(0, 7));
        blit(150, 100, 1'b0, 3'd0, -1, -1, 1'b0);
        for (int i = 0; i < 2048; i++) rom[i] = 3'b111;
        blit(20, 30, 1'b1, 3'd0, -1, -1, 1'b0);
        for (int i = 0; i < 2048; i++) rom[i] = 3'($urandom_range(0, 7));
        blit(30, 20, 1'b0, 3'd2, 500, 800, 1'b0);
        blit(30, 20, 1'b0, 3'd2, 500, -1, 1'b1);
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 2048; i++) rom[i] = 3'($urandom_range(0, 7));
            blit(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1'($urandom),
                 3'($urandom), -1, -1, 1'($urandom));
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
